// File: rtl/wb_arbiter.sv
// Writeback arbiter: grants up to wwd ready FU result lanes per cycle into a registered writeback stage.
// Define WBARB_RR_EN for a rotating FU priority pointer; otherwise FU0 always has highest priority.
package wb_arbiter_pkg;
    typedef struct packed {
        logic [15:0] opid;
        logic [63:0] npc;
        logic [7:0]  prda;
        logic [63:0] prdv;
    } exe_bundle_t;
endpackage

module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned nfu = 4,
    parameter int unsigned ewd = 4,
    parameter int unsigned wwd = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              flush,
    input  exe_bundle_t [nfu-1:0][ewd-1:0]    resp,
    output logic        [nfu-1:0][ewd-1:0]    claim,
    output exe_bundle_t [wwd-1:0]             wb,
    input  logic                              wb_ready
);
    localparam int unsigned pw = (nfu > 1) ? $clog2(nfu) : 1;
    localparam int unsigned lw = (ewd > 1) ? $clog2(ewd) : 1;
    localparam int unsigned iw = (wwd > 1) ? $clog2(wwd) : 1;
    localparam int unsigned cw = $clog2(wwd + 1);
    localparam logic [pw:0]   nfu_c = (pw + 1)'(nfu);
    localparam logic [cw-1:0] wwd_c = cw'(wwd);

    logic [pw-1:0] p;
    logic          wb_busy;
    logic          load;
    logic          take;
    exe_bundle_t [wwd-1:0] wb_next;
    logic [cw-1:0] cnt;
    logic [pw:0]   fidx;
    logic [pw-1:0] f;
    logic [lw-1:0] li;
`ifdef WBARB_RR_EN
    logic          any_grant;
    logic [pw-1:0] last_f;
    logic [pw:0]   p_inc;
`endif

    always_comb begin
        wb_busy = 1'b0;
        for (int unsigned i = 0; i < wwd; i++) begin
            wb_busy = wb_busy | wb[i].opid[15];
        end
    end

    assign load = ~wb_busy | wb_ready;
    assign take = load & ~rst & ~flush;

    // Scan FUs from p with wraparound; within an FU, lanes in ascending order.
    always_comb begin
        wb_next = '0;
        claim   = '0;
        cnt     = '0;
        fidx    = '0;
        f       = '0;
        li      = '0;
`ifdef WBARB_RR_EN
        any_grant = 1'b0;
        last_f    = '0;
`endif
        if (take) begin
            for (int unsigned k = 0; k < nfu; k++) begin
                fidx = {1'b0, p} + (pw + 1)'(k);
                if (fidx >= nfu_c) begin
                    fidx = fidx - nfu_c;
                end
                f = fidx[pw-1:0];
                for (int unsigned l = 0; l < ewd; l++) begin
                    li = lw'(l);
                    if (resp[f][li].opid[15] && (cnt < wwd_c)) begin
                        claim[f][li]          = 1'b1;
                        wb_next[cnt[iw-1:0]]  = resp[f][li];
                        cnt                   = cnt + cw'(1);
`ifdef WBARB_RR_EN
                        any_grant = 1'b1;
                        last_f    = f;
`endif
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wb <= '0;
        end else if (load) begin
            wb <= wb_next;
        end
    end

`ifdef WBARB_RR_EN
    always_comb begin
        p_inc = {1'b0, last_f} + (pw + 1)'(1);
        if (p_inc >= nfu_c) begin
            p_inc = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            p <= '0;
        end else if (take && any_grant) begin
            p <= p_inc[pw-1:0];
        end
    end
`else
    assign p = '0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter; expectations follow WBARB_RR_EN when defined.
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    logic wb_ready;
    exe_bundle_t [3:0][3:0] resp;
    logic        [3:0][3:0] claim;
    exe_bundle_t [3:0]      wb;
    exe_bundle_t [3:0]      wbe;

    int checks = 0;
    int errors = 0;
    int idle_claims;
    int pulses;
    int wb_hits;
    logic ret;

    wb_arbiter #(.nfu(4), .ewd(4), .wwd(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .resp     (resp),
        .claim    (claim),
        .wb       (wb),
        .wb_ready (wb_ready)
    );

    always #5 clk = ~clk;

    function automatic exe_bundle_t mk(input logic [15:0] opid, input logic [63:0] prdv);
        exe_bundle_t b;
        b.opid = opid;
        b.npc  = 64'hA000_0000 + {48'd0, opid};
        b.prda = opid[7:0];
        b.prdv = prdv;
        return b;
    endfunction

    task automatic check(input string tag, input logic [639:0] obs, input logic [639:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        wb_ready = 1'b1;
        resp = '0;
        tick;
        #1 check("rst_claim", claim, 16'h0000);
        tick;
        check("rst_wb", wb, '0);
        check("rst_p", dut.p, 2'd0);
        rst = 1'b0;

        // Single lane FU2/lane0
        resp[2][0] = mk(16'h8005, 64'h1234);
        #1 check("t1_claim", claim, 16'h0100);
        tick;
        resp = '0;
        wbe = '0;
        wbe[0] = mk(16'h8005, 64'h1234);
        check("t1_wb", wb, wbe);
`ifdef WBARB_RR_EN
        check("t1_p", dut.p, 2'd3);
`else
        check("t1_p", dut.p, 2'd0);
`endif
        flush = 1'b1;
        tick;
        flush = 1'b0;

        // All 16 lanes valid
        for (int fu = 0; fu < 4; fu++) begin
            for (int ln = 0; ln < 4; ln++) begin
                resp[fu][ln] = mk(16'h8000 + 16'(fu * 16 + ln), 64'(fu * 4 + ln));
            end
        end
        #1 check("t2_claim1", claim, 16'h000F);
        tick;
        for (int ln = 0; ln < 4; ln++) wbe[ln] = mk(16'h8000 + 16'(ln), 64'(ln));
        check("t2_wb1", wb, wbe);
`ifdef WBARB_RR_EN
        check("t2_p1", dut.p, 2'd1);
`else
        check("t2_p1", dut.p, 2'd0);
`endif
        for (int ln = 0; ln < 4; ln++) resp[0][ln] = mk(16'h8100 + 16'(ln), 64'h100 + 64'(ln));
`ifdef WBARB_RR_EN
        #1 check("t2_claim2", claim, 16'h00F0);
        tick;
        for (int ln = 0; ln < 4; ln++) wbe[ln] = mk(16'h8010 + 16'(ln), 64'(4 + ln));
        check("t2_wb2", wb, wbe);
        check("t2_p2", dut.p, 2'd2);
`else
        #1 check("t2_claim2", claim, 16'h000F);
        tick;
        for (int ln = 0; ln < 4; ln++) wbe[ln] = mk(16'h8100 + 16'(ln), 64'h100 + 64'(ln));
        check("t2_wb2", wb, wbe);
        check("t2_p2", dut.p, 2'd0);
`endif
        resp = '0;

        // Backpressure for 3 cycles, then same-cycle handoff
        wb_ready = 1'b0;
        resp[1][0] = mk(16'h8010, 64'hBEEF);
        repeat (3) begin
            #1 check("t3_hold_claim", claim, 16'h0000);
            tick;
            check("t3_hold_wb", wb, wbe);
        end
        wb_ready = 1'b1;
        #1 check("t3_release_claim", claim, 16'h0010);
        tick;
        resp = '0;
        wbe = '0;
        wbe[0] = mk(16'h8010, 64'hBEEF);
        check("t3_release_wb", wb, wbe);

        // Long-latency source on FU3 lane0
        idle_claims = 0;
        repeat (65) begin
            #1 if (claim != '0) idle_claims++;
            tick;
        end
        check("t4_idle_claims", 32'(idle_claims), 32'd0);
        check("t4_idle_wb", wb, '0);
`ifdef WBARB_RR_EN
        check("t4_idle_p", dut.p, 2'd2);
`else
        check("t4_idle_p", dut.p, 2'd0);
`endif
        resp[3][0] = mk(16'h8333, 64'hD1D1);
        pulses = 0;
        wb_hits = 0;
        ret = 1'b0;
        repeat (8) begin
            #1 if (claim[3][0]) begin
                pulses++;
                ret = 1'b1;
            end
            tick;
            for (int ln = 0; ln < 4; ln++) begin
                if (wb[ln].opid == 16'h8333) wb_hits++;
            end
            if (ret) begin
                resp[3][0] = '0;
                ret = 1'b0;
            end
        end
        check("t4_claim_pulses", 32'(pulses), 32'd1);
        check("t4_wb_hits", 32'(wb_hits), 32'd1);

        // Flush with wb occupied and two lanes pending
        resp[0][0] = mk(16'h8020, 64'h20);
        tick;
        resp = '0;
        resp[1][0] = mk(16'h8041, 64'h41);
        resp[2][1] = mk(16'h8052, 64'h52);
        flush = 1'b1;
        #1 check("t5_flush_claim", claim, 16'h0000);
        tick;
        flush = 1'b0;
        check("t5_flush_wb", wb, '0);
        check("t5_flush_p", dut.p, 2'd0);
        #1 check("t5_after_claim", claim, 16'h0210);
        tick;
        resp = '0;
        wbe = '0;
        wbe[0] = mk(16'h8041, 64'h41);
        wbe[1] = mk(16'h8052, 64'h52);
        check("t5_after_wb", wb, wbe);

        // Reset during backpressure
        wb_ready = 1'b0;
        resp[3][1] = mk(16'h8071, 64'h71);
        #1 check("t6_bp_claim", claim, 16'h0000);
        tick;
        check("t6_bp_wb", wb, wbe);
        rst = 1'b1;
        #1 check("t6_rst_claim1", claim, 16'h0000);
        tick;
        check("t6_rst_wb", wb, '0);
        #1 check("t6_rst_claim2", claim, 16'h0000);
        tick;
        rst = 1'b0;
        #1 check("t6_post_claim", claim, 16'h2000);
        tick;
        resp = '0;
        wbe = '0;
        wbe[0] = mk(16'h8071, 64'h71);
        check("t6_post_wb", wb, wbe);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter for the execution cluster. It sits on the consumer side of the `resp`/`claim` result interface that every functional unit (ALU, MUL, DIV, LSU) exposes. Each cycle it selects up to `wwd` ready results across all units and asserts `claim` on exactly those lanes. The selected results are registered into a `wwd`-wide writeback stage feeding the register file and the commit logic.

## Interface
- `nfu`, 4: number of functional units attached.
- `ewd`, 4: result lanes per functional unit; matches the FU `resp`/`claim` width.
- `wwd`, 4: writeback lanes per cycle.
- `clk`  in  1  clock.
- `rst`  in  1  reset: synchronous, active-high.
- `flush`  in  1  pipeline flush. Synchronous; same effect on state as `rst`.
- `resp`  in  `exe_bundle_t [nfu-1:0][ewd-1:0]`  FU results. Lane valid iff `opid[15]`.
- `claim`  out  `[nfu-1:0][ewd-1:0]`  accept strobe per FU lane. Combinational.
- `wb`  out  `exe_bundle_t [wwd-1:0]`  registered writeback bundles. Lane valid iff `opid[15]`.
- `wb_ready`  in  1  downstream consumes all valid `wb` lanes this cycle.

## Operation
- Output stage `wb` accepts new data when `load = ~|valid(wb) | wb_ready`.
- When `load` is 0, or `flush`/`rst` is asserted, `claim` is all-zero.
- Scan order:
  - FUs are scanned starting at priority pointer `p`, then `p+1` and onward, wrapping mod `nfu`.
  - Within each FU, lanes are scanned 0..`ewd-1`.
- The first `wwd` valid lanes in scan order are granted. Granted lane k in scan order goes to `wb[k]`; remaining `wb` lanes are loaded with 0.
- `claim[f][l]=1` iff lane (f,l) is granted. A claimed FU retires that result at the same edge. The arbiter never claims an invalid lane.
- Ungranted valid lanes stay asserted by their FU and are re-offered next cycle; nothing is dropped.
- Pointer update on `load` with at least one grant: `p <= (last granted FU + 1) mod nfu`.
- Pointer is unchanged when nothing is granted, or when `load`=0.
- `npc`, `prda` and `prdv` pass through unmodified; the arbiter does no arithmetic on payload.
- Only the pointer `p` (`$clog2(nfu)` bits) and `wb` are stateful.

## Timing
- Reset/flush: `wb` <= 0 (all lanes invalid), `p` <= 0, `claim`=0 in that cycle. A result already claimed before the flush edge is discarded by the flush.
- Latency: an FU result valid in cycle t with `load`=1 is claimed in t and appears on `wb` in t+1.
- Throughput: `wwd` results/cycle with no bubbles while `wb_ready`=1.
- Backpressure: `wb_ready`=0 with valid `wb` holds `wb` stable and keeps `claim`=0 until `wb_ready`=1.
  - In the cycle `wb_ready` returns to 1, new grants load in the same cycle; this is a full-throughput handoff.
- Fewer than `wwd` valid lanes: all valid lanes are granted, and the unused upper `wb` lanes are 0.
- All lanes empty: `wb` <= 0 on `load`, and `p` is held.
- `p` wraps from `nfu-1` to 0.

## Configuration
- `WBARB_RR_EN` defined: rotating priority pointer as described above. Guarantees every FU is granted within `nfu` loaded cycles while it stays valid.
- `WBARB_RR_EN` undefined: fixed priority, with `p` tied to 0 (FU0 highest, FU `nfu-1` lowest) and no pointer register. Starvation of high-index FUs is permitted.

## Test plan
- Reset, then FU2 lane0 valid with opid=16'h8005, prdv=64'h1234 -> `claim[2][0]`=1 in the same cycle; next cycle `wb[0].opid`=16'h8005, `wb[0].prdv`=64'h1234, `wb[1..3]`=0, `p`=3.
- All 16 lanes valid with `wb_ready`=1 and `p`=0 -> cycle 1 grants FU0 lanes 0-3 and `p`=1; cycle 2 grants FU1 lanes 0-3 (FU0 re-presents new data).
  - With `WBARB_RR_EN` undefined, FU0 is granted in both cycles.
- `wb` valid with `wb_ready`=0 held for 3 cycles while FU1 lane0 is valid -> `claim`=0 throughout and `wb` stable; `wb_ready`=1 -> FU1 lane0 claimed that same cycle and appears on `wb[0]` next cycle.
- DIV-style source presents FU3 lane0 valid only after 65 cycles, then holds it until claimed -> exactly one `claim[3][0]` pulse, and exactly one `wb` entry with matching opid.
- `flush` asserted while 2 lanes are valid and `wb` holds data -> `claim`=0 that cycle; next cycle `wb`=0 and `p`=0.
- `rst` asserted mid-backpressure (`wb_ready`=0, `wb` valid) -> `wb` cleared next cycle, and no claims are issued during reset.
